// File: rtl/party_color_sequencer.sv
// Party colour sequencer: picks the alive/dead colour pair fed to the
// renderer. Static schemes follow colorSwitch; party mode cycles through a
// pseudo-random palette. Every colour change lands on a frame boundary.
//
// Handshake note: gen_tick and frame_done are single-cycle strobes with no
// back-pressure. A strobe is consumed on the rising edge that samples it high.
// pending is a level that says "a new pair is armed and the next frame_done
// will commit it".
module party_color_sequencer #(
    parameter int          NUM_COLORS = 10,
    parameter int          HOLD_GENS  = 8,
    parameter logic [15:0] LFSR_SEED  = 16'hACE1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        partySwitch,
    input  logic        colorSwitch,
    input  logic        gen_tick,
    input  logic        frame_done,
    output logic [23:0] alive,
    output logic [23:0] dead,
    output logic [3:0]  color_idx,
    output logic        pending,
    output logic [1:0]  dbg_state
);

    localparam logic [1:0] ST_STATIC = 2'd0;
    localparam logic [1:0] ST_PICK   = 2'd1;
    localparam logic [1:0] ST_ARMED  = 2'd2;
    localparam logic [1:0] ST_HOLD   = 2'd3;

    // A zero seed would lock the LFSR, so it is replaced.
    localparam logic [15:0] SEED = (LFSR_SEED == 16'h0000) ? 16'h0001 : LFSR_SEED;

    // Dwell must be able to hold HOLD_GENS so it can saturate without wrapping.
    localparam int            DW         = $clog2(HOLD_GENS + 1);
    localparam logic [DW-1:0] DWELL_LAST = DW'(HOLD_GENS - 1);
    localparam logic [DW-1:0] DWELL_MAX  = '1;

    localparam logic [23:0] PARTY_DEAD = 24'h808080;

    logic          r_psw_meta;
    logic          r_psw;
    logic          r_csw_meta;
    logic          r_csw;
    logic [15:0]   r_lfsr;
    logic [1:0]    r_state;
    logic [23:0]   r_alive;
    logic [23:0]   r_dead;
    logic [3:0]    r_color_idx;
    logic [3:0]    r_next_idx;
    logic          r_has_party;
    logic [DW-1:0] r_dwell;

    logic [23:0]   w_tgt_alive;
    logic [23:0]   w_tgt_dead;
    logic          w_static_diff;
    logic [3:0]    w_cand;
    logic          w_cand_ok;

    function automatic logic [23:0] f_palette(input logic [3:0] idx);
        case (idx)
            4'd0:    f_palette = 24'hFF6EC7;
            4'd1:    f_palette = 24'h808000;
            4'd2:    f_palette = 24'hA8FF00;
            4'd3:    f_palette = 24'hFFD300;
            4'd4:    f_palette = 24'h00FFFF;
            4'd5:    f_palette = 24'hB300FF;
            4'd6:    f_palette = 24'h00FF00;
            4'd7:    f_palette = 24'hFF00FF;
            4'd8:    f_palette = 24'hFF6600;
            4'd9:    f_palette = 24'hFF3333;
            default: f_palette = 24'h000000;
        endcase
    endfunction

    // Two-flop synchronisers for the asynchronous switches.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_psw_meta <= 1'b0;
            r_psw      <= 1'b0;
            r_csw_meta <= 1'b0;
            r_csw      <= 1'b0;
        end else begin
            r_psw_meta <= partySwitch;
            r_psw      <= r_psw_meta;
            r_csw_meta <= colorSwitch;
            r_csw      <= r_csw_meta;
        end
    end

    // Free-running Galois LFSR (taps 16,14,13,11), stepping every clock.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_lfsr <= SEED;
        end else begin
            r_lfsr <= {1'b0, r_lfsr[15:1]} ^ (r_lfsr[0] ? 16'hB400 : 16'h0000);
        end
    end

    // Static target pair, candidate acceptance and the pending flag.
    always_comb begin
        w_tgt_alive   = r_csw ? 24'h00FF00 : 24'hFF0000;
        w_tgt_dead    = r_csw ? 24'hFF0000 : 24'h0000FF;
        w_static_diff = (w_tgt_alive != r_alive) || (w_tgt_dead != r_dead);
        w_cand        = r_lfsr[3:0];
        // Repeat exclusion only matters once a party colour is on screen.
        w_cand_ok     = (int'(w_cand) < NUM_COLORS) &&
                        !(r_has_party && (w_cand == r_color_idx));
        pending       = (r_state == ST_ARMED) ||
                        ((r_state == ST_STATIC) && !r_psw && w_static_diff);
    end

    // Mode FSM; committed colours only change on a sampled frame_done.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= ST_STATIC;
            r_alive     <= 24'hFF0000;
            r_dead      <= 24'h0000FF;
            r_color_idx <= 4'd0;
            r_next_idx  <= 4'd0;
            r_has_party <= 1'b0;
            r_dwell     <= '0;
        end else begin
            case (r_state)
                ST_STATIC: begin
                    if (r_psw) begin
                        r_state <= ST_PICK;
                    end else if (frame_done && w_static_diff) begin
                        r_alive     <= w_tgt_alive;
                        r_dead      <= w_tgt_dead;
                        r_color_idx <= 4'd0;
                        r_has_party <= 1'b0;
                    end
                end
                ST_PICK: begin
                    if (!r_psw) begin
                        r_state <= ST_STATIC;
                    end else if (w_cand_ok) begin
                        r_next_idx <= w_cand;
                        r_state    <= ST_ARMED;
                    end
                end
                ST_ARMED: begin
                    if (!r_psw) begin
                        r_state <= ST_STATIC;
                    end else if (frame_done) begin
                        r_alive     <= f_palette(r_next_idx);
                        r_dead      <= PARTY_DEAD;
                        r_color_idx <= r_next_idx;
                        r_has_party <= 1'b1;
                        r_dwell     <= '0;
                        r_state     <= ST_HOLD;
                    end
                end
                ST_HOLD: begin
                    if (!r_psw) begin
                        r_state <= ST_STATIC;
                    end else if (gen_tick) begin
                        if (r_dwell != DWELL_MAX) begin
                            r_dwell <= r_dwell + 1'b1;
                        end
                        if (r_dwell == DWELL_LAST) begin
                            r_state <= ST_PICK;
                        end
                    end
                end
                default: r_state <= ST_STATIC;
            endcase
        end
    end

    assign alive     = r_alive;
    assign dead      = r_dead;
    assign color_idx = r_color_idx;
    assign dbg_state = r_state;

endmodule
